// File: rtl/fxp_add_sub_pipe.sv
// fxp_add_sub_pipe: two-stage Q(WIDTH-FRAC).FRAC add/sub/accumulate pipeline with valid/ready handshakes.
// Build option: define FXP_ADD_SUB_SAT_EN to saturate overflowed results instead of wrapping them.
module fxp_add_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             errorwarning,
  output logic             ovf_sticky
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  generate
    if (WIDTH < 8 || WIDTH > 64 || FRAC < 0 || FRAC > WIDTH) begin : g_bad_param
      $error("fxp_add_sub_pipe: WIDTH must be 8..64 and FRAC must be 0..WIDTH");
    end
  endgenerate

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_x1_q, s1_x1_d;
  logic [WIDTH-1:0] s1_x2_q, s1_x2_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ew_q, ew_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             s2_advance;
  logic [WIDTH:0]   a_ext, b_ext, acc_ext, sum;
  logic             ovf;
  logic [WIDTH-1:0] res;

  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_advance;

    a_ext   = {s1_x1_q[WIDTH-1], s1_x1_q};
    b_ext   = {s1_x2_q[WIDTH-1], s1_x2_q};
    acc_ext = {acc_q[WIDTH-1], acc_q};
    case (s1_op_q)
      OP_ADD:  sum = a_ext + b_ext;
      OP_SUB:  sum = a_ext - b_ext;
      OP_ACC:  sum = acc_ext + a_ext;
      default: sum = a_ext;
    endcase
    // A load is a plain sign-extended copy, so it can never flag overflow.
    ovf = (s1_op_q != OP_LOAD) && (sum[WIDTH] != sum[WIDTH-1]);
`ifdef FXP_ADD_SUB_SAT_EN
    if (ovf) res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     res = sum[WIDTH-1:0];
`else
    res = sum[WIDTH-1:0];
`endif

    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_x1_d     = s1_x1_q;
    s1_x2_d     = s1_x2_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ew_d        = ew_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_x1_d = x1;
        s1_x2_d = x2;
      end
    end

    // acc moves on the same edge the result lands in S2, so the next op in S1 sees it.
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d  = res;
        ew_d = ovf;
        if (s1_op_q == OP_ACC || s1_op_q == OP_LOAD) acc_d = res;
      end
    end

    if (out_valid_q && out_ready && ew_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_x1_q     <= '0;
      s1_x2_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ew_q        <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_x1_q     <= s1_x1_d;
      s1_x2_q     <= s1_x2_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ew_q        <= ew_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign y            = y_q;
  assign errorwarning = ew_q;
  assign ovf_sticky   = sticky_q;
endmodule

// File: tb/tb_fxp_add_sub_pipe.sv
// Bench for fxp_add_sub_pipe (WIDTH=32): integer reference model, per-cycle output compare, directed vectors.
module tb_fxp_add_sub_pipe;
  localparam int W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] x1 = '0;
  logic [W-1:0] x2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         errorwarning;
  logic         ovf_sticky;

  int total = 0;
  int bad = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] out_log[$];
  longint       model_acc = 0;
  logic         model_sticky = 1'b0;

  fxp_add_sub_pipe #(.WIDTH(W), .FRAC(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .errorwarning(errorwarning), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer result, then overflow test against the signed range.
  task automatic model_push(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    logic   ov;
    logic [W-1:0] ye;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = model_acc + sa;
      default: r = sa;
    endcase
    ov = (r > MAXV) || (r < MINV);
`ifdef FXP_ADD_SUB_SAT_EN
    if (ov) r = (r > 0) ? MAXV : MINV;
`endif
    ye = r[W-1:0];
    if (o[1]) model_acc = longint'($signed(ye));
    exp_q.push_back({ov, ye});
  endtask

  // Called right after a rising edge; returns right after the edge that transferred the input.
  task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    op = o; x1 = a; x2 = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 50) begin
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_push(o, a, b);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    exp_q.delete();
    model_acc = 0;
    model_sticky = 1'b0;
    #1 reset = 1'b0;
  endtask

  // Compare process: every cycle, away from the rising edge.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_y;
  logic         prev_ew;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      check("ovf_sticky", ovf_sticky, model_sticky);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_y", y, prev_y);
        check("stall_ew", errorwarning, prev_ew);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("y", y, e[W-1:0]);
          check("errorwarning", errorwarning, e[W]);
          out_log.push_back(y);
          if (errorwarning) model_sticky = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y = y;
      prev_ew = errorwarning;
    end
  end

  int base;
  int idx;
  logic took;
  logic [W-1:0] bp_x1[4];

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y", y, 0);
    check("rst_sticky", ovf_sticky, 0);
    @(posedge clk); #1;

    // add, with latency pinned
    base = out_log.size();
    send(2'b00, 32'h1E3BE76D, 32'h0AA147AE);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    drain();
    check("add_y_lit", out_log[base], 32'h28DD2F1B);

    base = out_log.size();
    send(2'b01, 32'h05000000, 32'h07000000);
    drain();
    check("sub_y_lit", out_log[base], 32'hFE000000);

    base = out_log.size();
    send(2'b00, 32'h7F000000, 32'h02000000);
    drain();
`ifdef FXP_ADD_SUB_SAT_EN
    check("ovf_y_lit", out_log[base], 32'h7FFFFFFF);
`else
    check("ovf_y_lit", out_log[base], 32'h81000000);
`endif
    check("ovf_sticky_lit", ovf_sticky, 1);

    // negative overflow via subtraction
    send(2'b01, 32'h80000000, 32'h00000001);
    drain();

    base = out_log.size();
    send(2'b11, 32'h01000000, 32'hDEADBEEF);
    send(2'b10, 32'h00800000, 32'h0);
    send(2'b10, 32'h00800000, 32'h0);
    send(2'b10, 32'h00800000, 32'h0);
    drain();
    check("acc0_lit", out_log[base],   32'h01000000);
    check("acc1_lit", out_log[base+1], 32'h01800000);
    check("acc2_lit", out_log[base+2], 32'h02000000);
    check("acc3_lit", out_log[base+3], 32'h02800000);

    // backpressure: 4 offered across 5 stalled cycles
    bp_x1[0] = 32'h00000011; bp_x1[1] = 32'h00000022;
    bp_x1[2] = 32'h00000033; bp_x1[3] = 32'h00000044;
    base = out_log.size();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        op = 2'b00; x1 = bp_x1[idx]; x2 = 32'h00000100; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      if (took) begin
        model_push(2'b00, bp_x1[idx], 32'h00000100);
        idx++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", idx, 2);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_y_held", y, 32'h00000111);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, bp_x1[2], 32'h00000100);
    send(2'b00, bp_x1[3], 32'h00000100);
    drain();
    check("bp_count", out_log.size() - base, 4);
    check("bp_order0", out_log[base],   32'h00000111);
    check("bp_order3", out_log[base+3], 32'h00000144);

    // reset with both stages full
    out_ready = 1'b0;
    send(2'b11, 32'h12345678, 32'h0);
    send(2'b00, 32'h7FFFFFFF, 32'h00000001);
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_no_out", out_valid, 0);
    @(posedge clk); #1;
    base = out_log.size();
    send(2'b10, 32'h00100000, 32'h0);
    drain();
    check("post_rst_acc_lit", out_log[base], 32'h00100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fxp_add_sub_pipe.md
FXP_ADD_SUB_PIPE -- requirements
Module: fxp_add_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits, two's-complement, legal range 8..64.
REQ-002 SHALL have parameter FRAC, default 24: fractional bits (Q(WIDTH-FRAC).FRAC); arithmetic-neutral, documents scaling 2^-FRAC.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  x1/x2/op valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port op  input  2  00 add x1+x2; 01 sub x1-x2; 10 accumulate acc+x1; 11 load acc<=x1.
REQ-008 SHALL have port x1  input  WIDTH  first operand.
REQ-009 SHALL have port x2  input  WIDTH  second operand, ignored for op 10/11.
REQ-010 SHALL have port out_valid  output  1  y/errorwarning valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port y  output  WIDTH  result.
REQ-013 SHALL have port errorwarning  output  1  signed overflow on this result.
REQ-014 SHALL have port ovf_sticky  output  1  set on any overflow handed off, cleared only by reset.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers op/x1/x2; S2 computes and registers y, errorwarning, out_valid.
REQ-016 SHALL transfer input when in_valid && in_ready; SHALL transfer output when out_valid && out_ready.
REQ-017 SHALL drive in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-018 SHALL give latency of exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput 1 result per cycle.
REQ-019 SHALL hold y, errorwarning and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute in WIDTH+1 bits; overflow = sign bit of the WIDTH+1 result differs from bit WIDTH-1.
REQ-021 SHALL update internal accumulator acc in S2 only for op 10 (acc <= y) and op 11 (acc <= x1, y = x1, errorwarning = 0), at the edge the result enters the S2 register.
REQ-022 SHALL make back-to-back accumulate ops use the acc updated by the preceding op (no hazard, no bubble).
REQ-023 SHALL leave acc unchanged for op 00/01.
REQ-024 SHALL set ovf_sticky on the output transfer of a result with errorwarning=1.
REQ-025 SHALL stall S1 when S2 is full and out_ready=0; no input is dropped or duplicated.

Reset
REQ-026 SHALL on reset clear s1_valid, out_valid, y, errorwarning, ovf_sticky and acc to 0; in_ready=1 in the first cycle after reset.
REQ-027 SHALL discard any in-flight operations when reset asserts mid-operation; no out_valid until new input is accepted after reset.
REQ-028 SHALL give reset priority over simultaneous input/output transfers.

Configuration
REQ-029 SHALL honour macro FXP_ADD_SUB_SAT_EN: when defined, overflowed results saturate to 0x7F..F (positive) or 0x80..0 (negative), and acc stores the saturated value.
REQ-030 SHALL without FXP_ADD_SUB_SAT_EN wrap results modulo 2^WIDTH; errorwarning is asserted identically in both builds.

Verification (WIDTH=32, FRAC=24)
REQ-031 SHALL test add: op=00, x1=0x1E3BE76D (30.234), x2=0x0AA147AE (10.63) -> 2 cycles later y=0x28DD2F1B (40.864), errorwarning=0.
REQ-032 SHALL test sub: op=01, x1=0x05000000, x2=0x07000000 -> y=0xFE000000 (-2.0), errorwarning=0.
REQ-033 SHALL test overflow: op=00, x1=0x7F000000, x2=0x02000000 -> errorwarning=1, ovf_sticky=1; y=0x81000000 without macro, y=0x7FFFFFFF with FXP_ADD_SUB_SAT_EN.
REQ-034 SHALL test accumulate: op=11 x1=0x01000000, then op=10 x1=0x00800000 three times back-to-back -> y=0x01000000, 0x01800000, 0x02000000, 0x02800000.
REQ-035 SHALL test backpressure: out_ready=0 for 5 cycles with 4 inputs offered -> exactly 2 accepted, in_ready=0 after, y held; on release all results emerge in order, none lost.
REQ-036 SHALL test reset mid-stream: reset with both stages full -> out_valid=0, ovf_sticky=0, acc=0; next op=10 x1=0x00100000 -> y=0x00100000.
